sys_ctrl_rx_cmd: RTL and testbench
==================================

Name: sys_ctrl_rx_cmd

Overview:
- Command-frame parser and controller in the destination (system) clock domain.
- Consumes synchronized bytes and their one-cycle valid pulses from the receive-path data synchronizer.
- Decodes register-write, register-read and ALU frames, drives register-file and ALU strobes, and pushes response bytes toward the transmit FIFO.
- Contains a single FSM plus a wait-state timeout counter.

Parameters:
- ADDR_WIDTH, 4, register-file address width.
- TIMEOUT, 255, max cycles spent in a wait state before abort (1..2^16-1).

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- RX_P_DATA  input  8  synchronized receive byte.
- RX_D_VLD  input  1  one-cycle valid pulse for RX_P_DATA.
- WrEn  output  1  register-file write strobe.
- RdEn  output  1  register-file read strobe.
- Address  output  ADDR_WIDTH  register-file address.
- WrData  output  8  register-file write data.
- RdData  input  8  register-file read data.
- RdData_Valid  input  1  RdData qualifier.
- ALU_EN  output  1  ALU start strobe.
- ALU_FUN  output  4  ALU function select.
- CLK_EN  output  1  ALU clock-gate enable.
- ALU_OUT  input  16  ALU result.
- OUT_VALID  input  1  ALU result qualifier.
- TX_P_DATA  output  8  response byte.
- TX_D_VLD  output  1  push strobe to the TX FIFO.
- FIFO_FULL  input  1  TX FIFO full.
- FRAME_ERR  output  1  one-cycle error pulse.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset: state IDLE; every output 0; internal latches and counter cleared. Reset mid-frame abandons the frame and emits no strobes.
- A byte is accepted only on a cycle with RX_D_VLD=1.
- All outputs are registered. A strobe caused by a byte accepted at edge N is high during cycle N+1, exactly one cycle long.
- Address, WrData and ALU_FUN hold their last value between strobes.
- IDLE:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> OPA.
  - 0xDD -> ALU_FN.
  - Any other byte -> FRAME_ERR pulse, stay IDLE.
- WR_ADDR: byte[ADDR_WIDTH-1:0] is latched as Address -> WR_DATA.
- WR_DATA: byte -> WrData, WrEn pulse -> IDLE.
- RD_ADDR: byte -> Address, RdEn pulse -> RD_WAIT.
- RD_WAIT: RdData_Valid=1 -> latch RdData -> TX_RD.
- TX_RD:
  - Edge with FIFO_FULL=0: TX_P_DATA=latched byte, TX_D_VLD pulse -> IDLE.
  - FIFO_FULL=1: hold indefinitely (no timeout).
- OPA: byte -> WrEn pulse, Address=0, WrData=byte -> OPB.
- OPB: same, with Address=1 -> ALU_FN.
- ALU_FN: byte -> ALU_FUN=byte[3:0], ALU_EN pulse -> ALU_WAIT. Bits [7:4] are ignored.
- CLK_EN: registered high from the edge entering ALU_FN through the edge leaving ALU_WAIT; low otherwise.
- ALU_WAIT: OUT_VALID=1 -> latch ALU_OUT -> TX_LO.
- TX_LO: when FIFO_FULL=0, push ALU_OUT[7:0] -> TX_HI.
- TX_HI: when FIFO_FULL=0, push ALU_OUT[15:8] -> IDLE. The two pushes are never in the same cycle; minimum spacing is one cycle.
- Timeout:
  - The counter clears on entry to RD_WAIT or ALU_WAIT and increments each cycle in those states.
  - When it reaches TIMEOUT with no qualifier: FRAME_ERR pulse -> IDLE, and no TX push.
  - A qualifier on the same cycle the count reaches TIMEOUT wins; no error.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_RD, TX_LO or TX_HI: the byte is dropped and FRAME_ERR pulses. The state is unaffected.
- RdData_Valid or OUT_VALID outside its wait state: ignored.

Test Plan:
- Write: bytes AA,05,3C (gaps of 3 cycles) -> exactly one WrEn cycle with Address=5, WrData=0x3C; RdEn, ALU_EN and FRAME_ERR stay 0.
- Read: bytes BB,07; model returns RdData=0x9E, valid 4 cycles after RdEn; FIFO_FULL held 1 for 5 cycles -> one RdEn with Address=7, then TX_D_VLD once with 0x9E, only after FIFO_FULL falls.
- ALU with operands: bytes CC,12,34,01; ALU_OUT=0xABCD -> WrEn at addr 0 (0x12) and addr 1 (0x34), ALU_EN with ALU_FUN=1, CLK_EN high through OUT_VALID, then pushes 0xCD followed by 0xAB.
- ALU without operands: bytes DD,F2 -> no WrEn, ALU_FUN=2. Timeout: TIMEOUT=8 with no OUT_VALID -> FRAME_ERR exactly 8 cycles after ALU_WAIT entry, return to IDLE, CLK_EN low, no TX push.
- Errors: byte 0x55 in IDLE -> one FRAME_ERR pulse, no strobes. A byte injected in RD_WAIT -> FRAME_ERR pulse, and the read still completes normally.
- Reset mid-frame: RST asserted after AA,05 -> all outputs 0 next cycle. A following AA,02,11 then writes addr 2 = 0x11 correctly.

Source files
------------

// File: rtl/sys_ctrl_rx_cmd.sv
// -----------------------------------------------------------------------------
// sys_ctrl_rx_cmd
//
// Command-frame parser and controller living in the system clock domain. It
// takes bytes from the receive-path synchronizer (one-cycle RX_D_VLD pulses),
// decodes register-write, register-read and ALU frames, drives the register
// file and ALU strobes, and pushes response bytes toward the transmit FIFO.
//
// Frames (first byte selects the frame type):
//   AA addr data        register write
//   BB addr             register read, read byte is returned on TX
//   CC opa opb fun      write operands to regs 0/1, start ALU, return result
//   DD fun              start ALU on current operands, return result
// ALU results are returned low byte first, then high byte.
//
// Ports:
//   CLK           system clock
//   RST           synchronous, active-high reset
//   RX_P_DATA     synchronized receive byte
//   RX_D_VLD      one-cycle valid pulse for RX_P_DATA
//   WrEn / RdEn   register-file write / read strobes (one cycle)
//   Address       register-file address (holds between strobes)
//   WrData        register-file write data (holds between strobes)
//   RdData        register-file read data, qualified by RdData_Valid
//   ALU_EN        ALU start strobe (one cycle)
//   ALU_FUN       ALU function select (holds between strobes)
//   CLK_EN        ALU clock-gate enable, high while an ALU op is in flight
//   ALU_OUT       ALU result, qualified by OUT_VALID
//   TX_P_DATA     response byte
//   TX_D_VLD      push strobe toward the TX FIFO
//   FIFO_FULL     TX FIFO full; pushes are held off while set
//   FRAME_ERR     one-cycle error pulse (bad command, stray byte, timeout)
//
// Every output is registered: a strobe caused by a byte accepted at a clock
// edge is high for exactly the following cycle.
// -----------------------------------------------------------------------------
module sys_ctrl_rx_cmd #(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [7:0]            WrData,
    input  logic [7:0]            RdData,
    input  logic                  RdData_Valid,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_EN,
    input  logic [15:0]           ALU_OUT,
    input  logic                  OUT_VALID,
    output logic [7:0]            TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL,
    output logic                  FRAME_ERR
);

    // Frame command bytes.
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPS = 8'hCC;
    localparam logic [7:0] CMD_ALU     = 8'hDD;

    // Fixed register-file locations of the ALU operands.
    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

    // The wait counter starts at 0 on entry and times out on the edge where
    // it would reach TIMEOUT, i.e. after exactly TIMEOUT cycles of waiting.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_TX_RD,
        ST_OPA,
        ST_OPB,
        ST_ALU_FN,
        ST_ALU_WAIT,
        ST_TX_LO,
        ST_TX_HI
    } state_e;

    state_e state_q, state_d;

    // Internal holding registers.
    logic [7:0]  rd_buf_q,   rd_buf_d;
    logic [15:0] alu_buf_q,  alu_buf_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Next values of the registered outputs.
    logic                  wr_en_d;
    logic                  rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [7:0]            wr_data_d;
    logic                  alu_en_d;
    logic [3:0]            alu_fun_d;
    logic                  clk_en_d;
    logic [7:0]            tx_data_d;
    logic                  tx_vld_d;
    logic                  frame_err_d;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below gets a default first so that no
        // path through the case statement leaves it unassigned (no latches).
        state_d     = state_q;
        rd_buf_d    = rd_buf_q;
        alu_buf_d   = alu_buf_q;
        wait_cnt_d  = wait_cnt_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_en_d    = 1'b0;
        tx_vld_d    = 1'b0;
        frame_err_d = 1'b0;
        addr_d      = Address;
        wr_data_d   = WrData;
        alu_fun_d   = ALU_FUN;
        tx_data_d   = TX_P_DATA;

        unique case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    unique case (RX_P_DATA)
                        CMD_WR:      state_d = ST_WR_ADDR;
                        CMD_RD:      state_d = ST_RD_ADDR;
                        CMD_ALU_OPS: state_d = ST_OPA;
                        CMD_ALU:     state_d = ST_ALU_FN;
                        default:     frame_err_d = 1'b1;
                    endcase
                end
            end

            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_WIDTH'(RX_P_DATA);
                    state_d = ST_WR_DATA;
                end
            end

            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d     = ADDR_WIDTH'(RX_P_DATA);
                    rd_en_d    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                // A stray byte is dropped and flagged; the read carries on.
                frame_err_d = RX_D_VLD;
                if (RdData_Valid) begin
                    // The qualifier wins even on the cycle the count expires.
                    rd_buf_d = RdData;
                    state_d  = ST_TX_RD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            ST_TX_RD: begin
                // No timeout here: a full FIFO may stall the response forever.
                frame_err_d = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_data_d = rd_buf_q;
                    tx_vld_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_OPA: begin
                if (RX_D_VLD) begin
                    addr_d    = OPA_ADDR;
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_OPB;
                end
            end

            ST_OPB: begin
                if (RX_D_VLD) begin
                    addr_d    = OPB_ADDR;
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_ALU_FN;
                end
            end

            ST_ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_fun_d  = RX_P_DATA[3:0];
                    alu_en_d   = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_ALU_WAIT;
                end
            end

            ST_ALU_WAIT: begin
                frame_err_d = RX_D_VLD;
                if (OUT_VALID) begin
                    alu_buf_d = ALU_OUT;
                    state_d   = ST_TX_LO;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            ST_TX_LO: begin
                frame_err_d = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_data_d = alu_buf_q[7:0];
                    tx_vld_d  = 1'b1;
                    state_d   = ST_TX_HI;
                end
            end

            ST_TX_HI: begin
                frame_err_d = RX_D_VLD;
                if (!FIFO_FULL) begin
                    tx_data_d = alu_buf_q[15:8];
                    tx_vld_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // The ALU clock runs while an operation is being set up or awaited;
        // deriving it from the next state makes it a plain registered level.
        clk_en_d = (state_d == ST_ALU_FN) || (state_d == ST_ALU_WAIT);
    end

    // ------------------------------------------------------------------------
    // State, holding and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments throughout, so every register samples
        // the values from before this edge regardless of statement order.
        if (RST) begin
            // NOTE: the holding buffers are reset too, so a frame abandoned by
            // reset can never leak stale data into a later response.
            state_q    <= ST_IDLE;
            rd_buf_q   <= '0;
            alu_buf_q  <= '0;
            wait_cnt_q <= '0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            Address    <= '0;
            WrData     <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VLD   <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_buf_q   <= rd_buf_d;
            alu_buf_q  <= alu_buf_d;
            wait_cnt_q <= wait_cnt_d;
            WrEn       <= wr_en_d;
            RdEn       <= rd_en_d;
            Address    <= addr_d;
            WrData     <= wr_data_d;
            ALU_EN     <= alu_en_d;
            ALU_FUN    <= alu_fun_d;
            CLK_EN     <= clk_en_d;
            TX_P_DATA  <= tx_data_d;
            TX_D_VLD   <= tx_vld_d;
            FRAME_ERR  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_sys_ctrl_rx_cmd.sv
// -----------------------------------------------------------------------------
// tb_sys_ctrl_rx_cmd
//
// Scoreboard bench for sys_ctrl_rx_cmd. The stimulus process drives directed
// frames and pushes the strobe events it expects (kind, fields, cycle) into a
// queue, plus occasional level expectations into a second queue. A monitor on
// the falling clock edge pops and compares whenever the DUT raises a strobe.
// -----------------------------------------------------------------------------
module tb_sys_ctrl_rx_cmd;

    localparam int AW = 4;
    localparam int TO = 8;

    logic          CLK;
    logic          RST;
    logic [7:0]    RX_P_DATA;
    logic          RX_D_VLD;
    logic          WrEn;
    logic          RdEn;
    logic [AW-1:0] Address;
    logic [7:0]    WrData;
    logic [7:0]    RdData;
    logic          RdData_Valid;
    logic          ALU_EN;
    logic [3:0]    ALU_FUN;
    logic          CLK_EN;
    logic [15:0]   ALU_OUT;
    logic          OUT_VALID;
    logic [7:0]    TX_P_DATA;
    logic          TX_D_VLD;
    logic          FIFO_FULL;
    logic          FRAME_ERR;

    sys_ctrl_rx_cmd #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_EN       (ALU_EN),
        .ALU_FUN      (ALU_FUN),
        .CLK_EN       (CLK_EN),
        .ALU_OUT      (ALU_OUT),
        .OUT_VALID    (OUT_VALID),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .FIFO_FULL    (FIFO_FULL),
        .FRAME_ERR    (FRAME_ERR)
    );

    typedef enum logic [2:0] {EV_WR, EV_RD, EV_ALU, EV_TX, EV_ERR} ev_e;
    typedef enum logic [1:0] {LV_ZERO, LV_CLKEN, LV_ADDR} lvl_e;

    typedef struct {
        ev_e        kind;
        logic [7:0] a;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    typedef struct {
        lvl_e        sel;
        logic [31:0] exp;
    } lvl_t;

    ev_t  exp_q[$];
    lvl_t lvl_q[$];

    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;
    logic done = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic score(input ev_e k, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_run++;
            n_fail++;
            $display("FAIL unexpected %s: actual a=%0h d=%0h at cycle %0d, expected no strobe",
                     k.name(), a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            check({k.name(), " kind/fields"}, {8'(k), a, d}, {8'(e.kind), e.a, e.d});
            check({k.name(), " cycle"}, cyc, e.cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        lvl_t l;
        while (lvl_q.size() > 0) begin
            l = lvl_q.pop_front();
            case (l.sel)
                LV_ZERO:  check("outputs zero", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN,
                                                 CLK_EN, TX_P_DATA, TX_D_VLD, FRAME_ERR}, l.exp);
                LV_CLKEN: check("clk_en level", 32'(CLK_EN), l.exp);
                LV_ADDR:  check("address hold", 32'(Address), l.exp);
                default:  check("level selector", 32'(l.sel), 32'hFFFF_FFFF);
            endcase
        end
        if (WrEn === 1'b1)      score(EV_WR,  8'(Address), WrData);
        if (RdEn === 1'b1)      score(EV_RD,  8'(Address), 8'h00);
        if (ALU_EN === 1'b1)    score(EV_ALU, 8'(ALU_FUN), 8'h00);
        if (TX_D_VLD === 1'b1)  score(EV_TX,  8'h00, TX_P_DATA);
        if (FRAME_ERR === 1'b1) score(EV_ERR, 8'h00, 8'h00);
        if (done) begin
            check("scoreboard drained", 32'(exp_q.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
            $finish;
        end
    end

    // ---------------------------------------------------------------- stimulus
    task automatic expect_ev(input ev_e k, input logic [7:0] a, input logic [7:0] d, input int c);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.d    = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_lvl(input lvl_e s, input logic [31:0] v);
        lvl_t l;
        l.sel = s;
        l.exp = v;
        lvl_q.push_back(l);
    endtask

    // Drive one byte; acc returns the cycle index of the edge that accepted it,
    // which is also the cycle in which its strobe is sampled by the monitor.
    task automatic send(input logic [7:0] b, output int acc);
        @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
        acc       = cyc;
    endtask

    initial begin : stim
        int t;
        int r;
        RST          = 1'b1;
        RX_P_DATA    = 8'h00;
        RX_D_VLD     = 1'b0;
        RdData       = 8'h00;
        RdData_Valid = 1'b0;
        ALU_OUT      = 16'h0000;
        OUT_VALID    = 1'b0;
        FIFO_FULL    = 1'b0;

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        expect_lvl(LV_ZERO, 32'd0);
        RST = 1'b0;

        // Register write AA,05,3C with 3-cycle gaps.
        send(8'hAA, t);
        repeat (3) @(posedge CLK);
        send(8'h05, t);
        repeat (3) @(posedge CLK);
        send(8'h3C, t);
        expect_ev(EV_WR, 8'h05, 8'h3C, t);
        repeat (3) @(posedge CLK);
        #1;
        expect_lvl(LV_ADDR, 32'd5);

        // Register read BB,07; data valid 4 cycles after RdEn, FIFO full 5 cycles.
        send(8'hBB, t);
        send(8'h07, t);
        expect_ev(EV_RD, 8'h07, 8'h00, t);
        repeat (3) @(posedge CLK);
        #1;
        RdData       = 8'h9E;
        RdData_Valid = 1'b1;
        FIFO_FULL    = 1'b1;
        @(posedge CLK);
        #1;
        RdData_Valid = 1'b0;
        RdData       = 8'h00;
        repeat (4) @(posedge CLK);
        #1;
        FIFO_FULL = 1'b0;
        expect_ev(EV_TX, 8'h00, 8'h9E, t + 9);
        repeat (3) @(posedge CLK);

        // ALU with operands CC,12,34,01; result ABCD, one stall before the high byte.
        send(8'hCC, t);
        send(8'h12, t);
        expect_ev(EV_WR, 8'h00, 8'h12, t);
        send(8'h34, t);
        expect_ev(EV_WR, 8'h01, 8'h34, t);
        send(8'h01, t);
        expect_ev(EV_ALU, 8'h01, 8'h00, t);
        repeat (2) @(posedge CLK);
        #1;
        expect_lvl(LV_CLKEN, 32'd1);
        ALU_OUT   = 16'hABCD;
        OUT_VALID = 1'b1;
        @(posedge CLK);
        #1;
        OUT_VALID = 1'b0;
        ALU_OUT   = 16'h0000;
        expect_ev(EV_TX, 8'h00, 8'hCD, t + 4);
        expect_ev(EV_TX, 8'h00, 8'hAB, t + 6);
        @(posedge CLK);
        #1;
        FIFO_FULL = 1'b1;
        expect_lvl(LV_CLKEN, 32'd0);
        @(posedge CLK);
        #1;
        FIFO_FULL = 1'b0;
        repeat (3) @(posedge CLK);

        // ALU without operands DD,F2, then timeout with no OUT_VALID.
        send(8'hDD, t);
        send(8'hF2, t);
        expect_ev(EV_ALU, 8'h02, 8'h00, t);
        expect_ev(EV_ERR, 8'h00, 8'h00, t + TO);
        expect_lvl(LV_CLKEN, 32'd1);
        repeat (TO + 3) @(posedge CLK);
        #1;
        expect_lvl(LV_CLKEN, 32'd0);

        // Bad command byte in IDLE.
        send(8'h55, t);
        expect_ev(EV_ERR, 8'h00, 8'h00, t);
        repeat (2) @(posedge CLK);

        // Read with a stray byte injected during RD_WAIT.
        send(8'hBB, t);
        send(8'h03, r);
        expect_ev(EV_RD, 8'h03, 8'h00, r);
        send(8'hAA, t);
        expect_ev(EV_ERR, 8'h00, 8'h00, t);
        @(posedge CLK);
        #1;
        RdData       = 8'h41;
        RdData_Valid = 1'b1;
        @(posedge CLK);
        #1;
        RdData_Valid = 1'b0;
        RdData       = 8'h00;
        expect_ev(EV_TX, 8'h00, 8'h41, r + 5);
        repeat (3) @(posedge CLK);

        // Reset mid-frame after AA,05, then a clean write AA,02,11.
        send(8'hAA, t);
        send(8'h05, t);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        expect_lvl(LV_ZERO, 32'd0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        send(8'hAA, t);
        send(8'h02, t);
        send(8'h11, t);
        expect_ev(EV_WR, 8'h02, 8'h11, t);

        repeat (5) @(posedge CLK);
        #1;
        done = 1'b1;
    end

endmodule
